// File: rtl/multicycle_controller.sv
// Control FSM for the RV32I multicycle core: sequences fetch/decode/execute/memory/writeback.
// Define CTRL_ITYPE_JAL_EN to add I-type ALU and jal support (EXECUTEI and JAL states).
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       trap
);

    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpBeq = 7'b1100011;
`ifdef CTRL_ITYPE_JAL_EN
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
`endif

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
`ifdef CTRL_ITYPE_JAL_EN
        StExecuteI,
        StJal,
`endif
        StAluWb,
        StBeq,
        StTrap
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = StExecuteR;
                    OpBeq:      state_d = StBeq;
`ifdef CTRL_ITYPE_JAL_EN
                    OpItype:    state_d = StExecuteI;
                    OpJal:      state_d = StJal;
`endif
                    default:    state_d = StTrap;
                endcase
            end
            StMemAdr:   state_d = (op == OpLw) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecuteR: state_d = StAluWb;
`ifdef CTRL_ITYPE_JAL_EN
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
`endif
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;

        case (op)
            OpSw:    ImmSrc = 2'b01;
            OpBeq:   ImmSrc = 2'b10;
`ifdef CTRL_ITYPE_JAL_EN
            OpJal:   ImmSrc = 2'b11;
`endif
            default: ImmSrc = 2'b00;
        endcase

        case (state_q)
            StFetch: begin
                // Reset holds the state in FETCH, so keep the PC/IR strobes quiet meanwhile.
                PCWrite   = mem_ready & ~reset;
                IRWrite   = mem_ready & ~reset;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            StExecuteR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
`ifdef CTRL_ITYPE_JAL_EN
            StExecuteI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
`endif
            StAluWb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StBeq: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                PCWrite    = zero;
                instr_done = 1'b1;
            end
            StTrap: begin
                ImmSrc = 2'b00;
                trap   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected outputs are queued
// from a hand-written state sequence per instruction and compared as the DUT steps.
module tb_multicycle_controller;

    localparam logic [6:0] OpLw    = 7'b0000011;
    localparam logic [6:0] OpSw    = 7'b0100011;
    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpBad   = 7'b1111111;

    localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5;
    localparam int SER = 6, SEI = 7, SAWB = 8, SBQ = 9, SJ = 10, ST = 11;

    typedef struct {
        logic [6:0]  op;
        logic        z;
        logic        mr;
        logic [16:0] exp;
    } item_t;

    item_t sb_q[$];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [16:0] obs;

    int n_checks = 0;
    int n_err = 0;

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
        .instr_done(instr_done),
        .trap      (trap)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
                  ImmSrc, RegWrite, instr_done, trap};

    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == OpSw) return 2'b01;
        if (o == OpBeq) return 2'b10;
`ifdef CTRL_ITYPE_JAL_EN
        if (o == OpJal) return 2'b11;
`endif
        return 2'b00;
    endfunction

    // Expected output vector for one cycle, straight from the per-state output table.
    function automatic logic [16:0] exp_out(input int st, input logic [6:0] o, input logic z,
                                            input logic mr);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, dn = 0, tr = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0, ao = 0, im;
        im = imm_of(o);
        case (st)
            SF:   begin sb = 2; rs = 2; irw = mr; pcw = mr; end
            SD:   begin sa = 1; sb = 1; end
            SMA:  begin sa = 2; sb = 1; end
            SMR:  adr = 1;
            SMWB: begin rs = 1; rw = 1; dn = 1; end
            SMW:  begin adr = 1; mw = 1; dn = mr; end
            SER:  begin sa = 2; ao = 2; end
            SEI:  begin sa = 2; sb = 1; ao = 2; end
            SAWB: begin rw = 1; dn = 1; end
            SBQ:  begin sa = 2; ao = 1; pcw = z; dn = 1; end
            SJ:   begin sa = 1; sb = 2; pcw = 1; end
            default: begin im = 0; tr = 1; end
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, ao, im, rw, dn, tr};
    endfunction

    task automatic push(input logic [6:0] o, input logic z, input logic mr, input int st);
        item_t it;
        it.op = o; it.z = z; it.mr = mr; it.exp = exp_out(st, o, z, mr);
        sb_q.push_back(it);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected state walk for one instruction, including memory stalls.
    task automatic push_instr(input logic [6:0] o, input int fstall, input int mstall,
                              input logic z);
        repeat (fstall) push(o, rbit(), 1'b0, SF);
        push(o, rbit(), 1'b1, SF);
        push(o, rbit(), rbit(), SD);
        case (o)
            OpLw: begin
                push(o, rbit(), rbit(), SMA);
                repeat (mstall) push(o, rbit(), 1'b0, SMR);
                push(o, rbit(), 1'b1, SMR);
                push(o, rbit(), rbit(), SMWB);
            end
            OpSw: begin
                push(o, rbit(), rbit(), SMA);
                repeat (mstall) push(o, rbit(), 1'b0, SMW);
                push(o, rbit(), 1'b1, SMW);
            end
            OpR: begin
                push(o, rbit(), rbit(), SER);
                push(o, rbit(), rbit(), SAWB);
            end
            OpBeq: push(o, z, rbit(), SBQ);
`ifdef CTRL_ITYPE_JAL_EN
            OpItype: begin
                push(o, rbit(), rbit(), SEI);
                push(o, rbit(), rbit(), SAWB);
            end
            OpJal: begin
                push(o, rbit(), rbit(), SJ);
                push(o, rbit(), rbit(), SAWB);
            end
`endif
            default: push(o, rbit(), rbit(), ST);
        endcase
    endtask

    task automatic drive(input item_t it);
        @(negedge clk);
        op = it.op; zero = it.z; mem_ready = it.mr;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = OpR; mem_ready = 1'b1;
        #2;
        n_checks++;
        if (obs !== exp_out(SF, OpR, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL reset_async: got %05h expected %05h", obs,
                              exp_out(SF, OpR, 1'b0, 1'b0));
        end
        @(negedge clk); #1;
        n_checks++;
        if (obs !== exp_out(SF, OpR, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL reset_held: got %05h expected %05h", obs,
                              exp_out(SF, OpR, 1'b0, 1'b0));
        end
        mem_ready = 1'b0; reset = 1'b0;
    endtask

    task automatic test_rtype();
        item_t it;
        int cyc = 0;
        push_instr(OpR, 0, 0, 1'b0);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); drive(it); cyc++; n_checks++;
            if (obs !== it.exp) begin
                n_err++; $display("FAIL rtype cycle %0d: got %05h expected %05h", cyc, obs, it.exp);
            end
        end
    endtask

    task automatic test_lw_stall();
        item_t it;
        int cyc = 0;
        push_instr(OpLw, 3, 2, 1'b0);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); drive(it); cyc++; n_checks++;
            if (obs !== it.exp) begin
                n_err++; $display("FAIL lw_stall cycle %0d: got %05h expected %05h", cyc, obs, it.exp);
            end
        end
    endtask

    task automatic test_beq();
        item_t it;
        int cyc = 0;
        push_instr(OpBeq, 0, 0, 1'b1);
        push_instr(OpBeq, 0, 0, 1'b0);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); drive(it); cyc++; n_checks++;
            if (obs !== it.exp) begin
                n_err++; $display("FAIL beq cycle %0d: got %05h expected %05h", cyc, obs, it.exp);
            end
        end
    endtask

    task automatic test_sw_stall();
        item_t it;
        int cyc = 0;
        push_instr(OpSw, 0, 2, 1'b0);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); drive(it); cyc++; n_checks++;
            if (obs !== it.exp) begin
                n_err++; $display("FAIL sw_stall cycle %0d: got %05h expected %05h", cyc, obs, it.exp);
            end
        end
    endtask

    // Assert reset mid-cycle and confirm FETCH outputs with quiet strobes and trap cleared.
    task automatic reset_pulse(input string name, input logic [6:0] o);
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1; op = o;
        #1;
        n_checks++;
        if (obs !== exp_out(SF, o, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL %s: got %05h expected %05h", name, obs,
                              exp_out(SF, o, 1'b0, 1'b0));
        end
        @(negedge clk);
        mem_ready = 1'b0; reset = 1'b0;
    endtask

    task automatic test_trap();
        item_t it;
        int cyc = 0;
        push_instr(OpBad, 0, 0, 1'b0);
        repeat (19) push(OpBad, rbit(), rbit(), ST);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); drive(it); cyc++; n_checks++;
            if (obs !== it.exp) begin
                n_err++; $display("FAIL trap cycle %0d: got %05h expected %05h", cyc, obs, it.exp);
            end
        end
        reset_pulse("trap_reset", OpBad);
    endtask

    task automatic test_jal_itype();
        item_t it;
        int cyc = 0;
`ifdef CTRL_ITYPE_JAL_EN
        push_instr(OpJal, 0, 0, 1'b0);
        push_instr(OpItype, 1, 0, 1'b0);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); drive(it); cyc++; n_checks++;
            if (obs !== it.exp) begin
                n_err++; $display("FAIL jal_itype cycle %0d: got %05h expected %05h", cyc, obs, it.exp);
            end
        end
`else
        for (int k = 0; k < 2; k++) begin
            logic [6:0] o;
            o = (k == 0) ? OpJal : OpItype;
            push_instr(o, 0, 0, 1'b0);
            push(o, rbit(), rbit(), ST);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front(); drive(it); cyc++; n_checks++;
                if (obs !== it.exp) begin
                    n_err++; $display("FAIL jal_itype_trap cycle %0d: got %05h expected %05h",
                                      cyc, obs, it.exp);
                end
            end
            reset_pulse("jal_itype_reset", o);
        end
`endif
    endtask

    task automatic test_abandon();
        item_t it;
        int cyc = 0;
        push(OpSw, 1'b0, 1'b1, SF);
        push(OpSw, 1'b0, 1'b1, SD);
        push(OpSw, 1'b0, 1'b1, SMA);
        push(OpSw, 1'b0, 1'b0, SMW);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); drive(it); cyc++; n_checks++;
            if (obs !== it.exp) begin
                n_err++; $display("FAIL abandon cycle %0d: got %05h expected %05h", cyc, obs, it.exp);
            end
        end
        reset_pulse("abandon_reset", OpSw);
    endtask

    task automatic test_back_to_back();
        item_t it;
        logic [6:0] ops [6];
        int n_ops;
        int cyc = 0;
        int done_cnt = 0;
        ops[0] = OpLw; ops[1] = OpSw; ops[2] = OpR; ops[3] = OpBeq;
        ops[4] = OpItype; ops[5] = OpJal;
`ifdef CTRL_ITYPE_JAL_EN
        n_ops = 6;
`else
        n_ops = 4;
`endif
        for (int i = 0; i < 10; i++) begin
            push_instr(ops[$urandom_range(0, n_ops - 1)], $urandom_range(0, 2),
                       $urandom_range(0, 2), rbit());
        end
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front(); drive(it); cyc++; n_checks++;
            done_cnt += int'(instr_done);
            if (obs !== it.exp) begin
                n_err++; $display("FAIL back_to_back cycle %0d: got %05h expected %05h",
                                  cyc, obs, it.exp);
            end
        end
        n_checks++;
        if (done_cnt !== 10) begin
            n_err++; $display("FAIL retire_count: got %0d expected 10", done_cnt);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_sw_stall();
        test_trap();
        test_jal_itype();
        test_abandon();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the RV32I multicycle core. It sequences the shared datapath: unified instruction/data memory, one ALU, and the register file. Each instruction walks through fetch, decode, execute, memory and writeback states. Memory accesses use a ready handshake.

## Interface
Parameters:
- none

Ports (all outputs are 1-bit unless a width is given):
- `clk`  in  1  core clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; forces state FETCH
- `op`  in  7  instruction opcode, taken from the instruction register (IR)
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the current access this cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result register
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction register (and OldPC) enable
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB`  out  2  ALU operand B select: 00 = rs2, 01 = imm, 10 = constant 4
- `ALUOp`  out  2  ALU operation class: 00 = add, 01 = sub, 10 = funct-decoded
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `RegWrite`  out  1  register file write enable
- `instr_done`  out  1  one-cycle pulse when an instruction retires
- `trap`  out  1  sticky; illegal opcode seen

## Operation
- State register encodes: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP.
- Outputs are decoded combinationally from state, `op`, `zero` and `mem_ready` (Moore-style plus qualifiers). Any output not listed for a state is 0.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=`mem_ready`; PCWrite=`mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target).
  - Next state by `op`:
    - 0000011 (lw) and 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXECUTER
    - 1100011 (beq) → BEQ
    - 0010011 (I-type ALU) → EXECUTEI, only when the macro is defined
    - 1101111 (jal) → JAL, only when the macro is defined
    - anything else → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if `op` is lw, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held for the whole wait. When `mem_ready`: instr_done=1 and go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=`zero`, instr_done=1. Goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Goes to ALUWB, which writes rd = OldPC+4; instr_done is asserted in ALUWB.
- TRAP: every output 0 except `trap`=1. Absorbing state; only `reset` exits.
- ImmSrc is decoded from `op` in every state: lw/I-type 00, sw 01, beq 10, jal 11, any other opcode 00.

## Timing
- Reset (asynchronous): state=FETCH immediately, `trap`=0.
  - While reset is held, outputs show FETCH values: PCWrite=IRWrite=`mem_ready` (forced to 0 while reset is asserted), MemWrite=0, RegWrite=0, instr_done=0.
- Instruction latency with `mem_ready` tied to 1:
  - lw 5 cycles, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. No strobe repeats: PC increments exactly once per fetch.
- `mem_ready` outside FETCH, MEMREAD and MEMWRITE is ignored.
- `reset` asserted mid-instruction abandons it: no RegWrite, no further MemWrite, no instr_done.
- `trap` asserts the cycle after DECODE sees an illegal opcode and stays high.
- `instr_done` is exactly one cycle per retired instruction.

## Configuration
- `CTRL_ITYPE_JAL_EN` defined:
  - EXECUTEI and JAL states are present.
  - Opcodes 0010011 and 1101111 execute as described above.
- Not defined:
  - Those states are removed.
  - Opcodes 0010011 and 1101111 go to TRAP like any illegal opcode.
  - ImmSrc for them is 00.

## Test plan
- Reset, then `mem_ready`=1 with `op`=0110011: states go FETCH→DECODE→EXECUTER→ALUWB. Check RegWrite=1 and instr_done=1 in cycle 4 only, PCWrite=1 in cycle 1.
- lw with `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEMREAD: retires in cycle 10. IRWrite is high for exactly 1 cycle; MEMWB has ResultSrc=01.
- beq with `zero`=1: PCWrite=1 in BEQ. Repeat with `zero`=0: PCWrite=0. Both retire in cycle 3.
- sw with `mem_ready`=0 for 2 cycles in MEMWRITE: MemWrite high for 3 cycles, AdrSrc=1, instr_done on the third cycle.
- `op`=1111111: `trap`=1 from cycle 3 onward, all strobes 0 for 20 cycles. Asserting `reset` clears `trap` and returns to FETCH.
- jal, run with and without `CTRL_ITYPE_JAL_EN`: with it, JAL has PCWrite=1 and ALUWB has RegWrite=1; without it, TRAP.
